fft_out_reorder: RTL and testbench
==================================

Name: fft_out_reorder

Overview:
- Consumer of the FFT output stream (out_valid, fo_re, fo_im).
- The FFT emits each frame of N = 2^logn complex samples in bit-reversed index order.
- This block writes each frame into a ping-pong buffer at bit-reversed addresses.
- It reads frames back in natural order (index 0..N-1) over a valid/ready handshake to downstream logic.

Parameters:
- FLOAT_PRECISION, 64, width of one real or imaginary float word.
- logn, 8, log2 of frame length N; N = 256 at default.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample valid from the FFT output; no backpressure exists on this side.
- di_re  input  FLOAT_PRECISION  real part of sample.
- di_im  input  FLOAT_PRECISION  imaginary part of sample.
- out_ready  input  1  downstream accepts the current output.
- out_valid  output  1  do_re/do_im/out_idx hold a valid natural-order sample.
- do_re  output  FLOAT_PRECISION  real part, registered.
- do_im  output  FLOAT_PRECISION  imaginary part, registered.
- out_idx  output  logn  natural-order index of the current output.
- overflow  output  1  sticky flag: a sample was dropped.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: out_valid=0, do_re=0, do_im=0, out_idx=0, overflow=0. Write counter=0, write bank=0, read bank=0, both bank_full flags=0.
- Buffer contents are not reset.
- Write side:
  - On each in_valid edge where bank_full[wb]=0, store {di_re, di_im} at address bitrev(wr_cnt) of bank wb, then increment wr_cnt.
  - When wr_cnt wraps from N-1 to 0: set bank_full[wb] and toggle wb.
- Overflow:
  - in_valid while bank_full[wb]=1 drops the sample, leaves wr_cnt unchanged and sets overflow.
  - overflow clears only on reset.
- Read FSM, states IDLE and STREAM:
  - IDLE -> STREAM when bank_full[rb]=1. On that edge, load do_re/do_im from address 0 of bank rb, set out_idx=0 and out_valid=1.
  - STREAM: on each edge with out_valid && out_ready, load address rd_cnt+1 and increment out_idx.
  - Holding: with out_ready=0, all outputs hold their values.
  - End of frame: the handshake on out_idx=N-1 clears bank_full[rb] and toggles rb.
    - If the other bank is full, the same edge loads its index 0 and out_valid stays 1 (back-to-back frames, no bubble).
    - Otherwise out_valid drops and the FSM returns to IDLE.
- Latency: if the last sample of a frame is sampled at edge E, then out_valid=1 with out_idx=0 after edge E+1 (reader idle).
- Simultaneous events:
  - A bank_full clear and a write to that bank in the same cycle: the write sees the pre-edge flag. The sample is dropped and overflow is set.
  - Reads and writes to different banks in the same cycle are independent.
- Reset mid-frame: the partial frame is discarded and out_valid drops immediately (asynchronous).
- bitrev(x) reverses the logn-bit index; no arithmetic is performed on data.

Optional Feature:
- Macro FFT_OUT_CONJ_EN.
- Defined: do_im is output with its MSB (IEEE sign bit) inverted, giving the complex conjugate for inverse-FFT reuse. do_re is unchanged. Latency is unchanged.
- Undefined: do_im equals the stored value bit-exactly.

Decomposition:
- Package fft_pkg holds:
  - FLOAT_PRECISION and logn defaults.
  - Complex-sample typedef {re, im}.
  - bitrev function parameterised by logn.
  - FSM state encoding (IDLE=0, STREAM=1).
- One sub-module: fft_bank_ram, an N-entry single-write / single-read storage of 2*FLOAT_PRECISION bits. It is instantiated twice (bank 0 and bank 1).

Test Plan:
- Single frame, logn=3:
  - Stimulus: 8 consecutive in_valid samples with re = bit-reversed index (order 0,4,2,6,1,5,3,7), out_ready=1.
  - Response: out_valid after edge E+1, do_re = 0..7 in order, out_idx = 0..7, then out_valid=0.
- Back-to-back frames, logn=3:
  - Stimulus: 16 continuous samples, out_ready=1.
  - Response: 16 outputs with no bubble between frames, overflow=0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles at out_idx=3.
  - Response: do_re, do_im and out_idx hold; the stream resumes at index 4.
- Overflow:
  - Stimulus: out_ready=0 while three full frames are pushed.
  - Response: both banks fill; the third frame's samples are dropped; overflow=1 and stays 1; the first two frames are later read intact.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after 3 samples.
  - Response: outputs return to 0 asynchronously. A following full frame reorders correctly from index 0.
- FFT_OUT_CONJ_EN defined:
  - Stimulus: di_im = 64'h3FF0000000000000 (1.0).
  - Response: do_im = 64'hBFF0000000000000 (-1.0); do_re is unchanged.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared defaults, sample type, bit-reverse helper and read FSM encoding for fft_out_reorder
package fft_pkg;

    localparam int FLOAT_PRECISION_DEF = 64;
    localparam int LOGN_DEF            = 8;

    typedef struct packed {
        logic [FLOAT_PRECISION_DEF-1:0] re;
        logic [FLOAT_PRECISION_DEF-1:0] im;
    } cplx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_t;

    // Reverse the low n bits of x; bits at and above n come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r[i] = x[n-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// rtl/fft_bank_ram.sv - one ping-pong bank: N entries, one write port, one combinational read port
module fft_bank_ram #(
    parameter int DW = 128,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1<<AW];

    // Contents are deliberately not reset; a bank is only read after it was fully written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - bit-reversed FFT output to natural order via ping-pong banks (FFT_OUT_CONJ_EN conjugates do_im)
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int FLOAT_PRECISION = FLOAT_PRECISION_DEF,
    parameter int logn            = LOGN_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [FLOAT_PRECISION-1:0] di_re,
    input  logic [FLOAT_PRECISION-1:0] di_im,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [FLOAT_PRECISION-1:0] do_re,
    output logic [FLOAT_PRECISION-1:0] do_im,
    output logic [logn-1:0]            out_idx,
    output logic                       overflow
);

    localparam int DW = 2 * FLOAT_PRECISION;
    localparam logic [logn-1:0] IDX_ONE = {{(logn-1){1'b0}}, 1'b1};
`ifdef FFT_OUT_CONJ_EN
    localparam logic [FLOAT_PRECISION-1:0] IM_FLIP = {1'b1, {(FLOAT_PRECISION-1){1'b0}}};
`else
    localparam logic [FLOAT_PRECISION-1:0] IM_FLIP = '0;
`endif

    logic [logn-1:0] wr_cnt;
    logic            wb;
    logic            rb;
    logic            rb_n;
    logic [1:0]      bank_full;
    logic [1:0]      set_full;
    logic [1:0]      clr_full;
    logic            wr_accept;
    logic            wr_wrap;
    logic [logn-1:0] wr_addr;
    logic [DW-1:0]   rdata0;
    logic [DW-1:0]   rdata1;
    logic [DW-1:0]   rd_data;
    rd_state_t       state;
    rd_state_t       state_n;
    logic            ld_en;
    logic            ld_bank;
    logic [logn-1:0] ld_addr;
    logic [logn-1:0] out_idx_n;
    logic            frame_done;

    // A sample is only taken when the bank being filled is free; otherwise it is dropped.
    assign wr_accept = in_valid && !bank_full[wb];
    assign wr_wrap   = wr_accept && (&wr_cnt);
    assign wr_addr   = (logn)'(bitrev(32'(wr_cnt), logn));
    assign set_full  = wr_wrap ? (wb ? 2'b10 : 2'b01) : 2'b00;
    assign clr_full  = frame_done ? (rb ? 2'b10 : 2'b01) : 2'b00;

    fft_bank_ram #(.DW(DW), .AW(logn)) u_bank0 (
        .clk   (clk),
        .we    (wr_accept && !wb),
        .waddr (wr_addr),
        .wdata ({di_re, di_im}),
        .raddr (ld_addr),
        .rdata (rdata0)
    );

    fft_bank_ram #(.DW(DW), .AW(logn)) u_bank1 (
        .clk   (clk),
        .we    (wr_accept && wb),
        .waddr (wr_addr),
        .wdata ({di_re, di_im}),
        .raddr (ld_addr),
        .rdata (rdata1)
    );

    assign rd_data = ld_bank ? rdata1 : rdata0;

    // Write counter, write bank and the sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt   <= '0;
            wb       <= 1'b0;
            overflow <= 1'b0;
        end else if (wr_accept) begin
            wr_cnt <= wr_cnt + IDX_ONE;
            if (&wr_cnt) begin
                wb <= !wb;
            end
        end else if (in_valid) begin
            overflow <= 1'b1;
        end
    end

    // Full flags: set by the writer on frame completion, cleared by the reader on its last handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= (bank_full | set_full) & ~clr_full;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Read FSM next state and buffer-read controls; all decisions use pre-edge full flags.
    always_comb begin
        state_n    = state;
        ld_en      = 1'b0;
        ld_bank    = rb;
        ld_addr    = out_idx + IDX_ONE;
        out_idx_n  = out_idx;
        rb_n       = rb;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (bank_full[rb]) begin
                    state_n   = STREAM;
                    ld_en     = 1'b1;
                    ld_addr   = '0;
                    out_idx_n = '0;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (&out_idx) begin
                        frame_done = 1'b1;
                        rb_n       = !rb;
                        if (bank_full[!rb]) begin
                            ld_en     = 1'b1;
                            ld_bank   = !rb;
                            ld_addr   = '0;
                            out_idx_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        ld_en     = 1'b1;
                        out_idx_n = out_idx + IDX_ONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered output sample, index and read bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb      <= 1'b0;
            out_idx <= '0;
            do_re   <= '0;
            do_im   <= '0;
        end else begin
            rb      <= rb_n;
            out_idx <= out_idx_n;
            if (ld_en) begin
                do_re <= rd_data[DW-1:FLOAT_PRECISION];
                do_im <= rd_data[FLOAT_PRECISION-1:0] ^ IM_FLIP;
            end
        end
    end

    assign out_valid = (state == STREAM);

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - self-checking bench for fft_out_reorder with a frame-queue reference model
module tb_fft_out_reorder;

    localparam int N  = 8;
    localparam int LN = 3;
`ifdef FFT_OUT_CONJ_EN
    localparam logic [63:0] IMF = 64'h8000000000000000;
`else
    localparam logic [63:0] IMF = 64'h0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [63:0]   di_re = '0;
    logic [63:0]   di_im = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [63:0]   do_re;
    logic [63:0]   do_im;
    logic [LN-1:0] out_idx;
    logic          overflow;

    int n_chk = 0;
    int n_fail = 0;

    fft_out_reorder #(.FLOAT_PRECISION(64), .logn(LN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .di_re     (di_re),
        .di_im     (di_im),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .do_re     (do_re),
        .do_im     (do_im),
        .out_idx   (out_idx),
        .overflow  (overflow)
    );

    always #5 clk = !clk;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int brev(input int k);
        int r;
        r = 0;
        for (int i = 0; i < LN; i++) begin
            if (k & (1 << i)) r = r | (1 << (LN - 1 - i));
        end
        return r;
    endfunction

    // Reference model: queue of complete frames in natural order, reader position, drop flag.
    logic [127:0] fq[$];
    logic [127:0] part [N];
    logic         m_valid = 1'b0;
    int           m_idx = 0;
    int           m_wcnt = 0;
    logic         m_ovf = 1'b0;
    int           m_occ;
    logic [127:0] cmp_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_wcnt  = 0;
            m_ovf   = 1'b0;
            fq.delete();
        end else begin
            m_occ = fq.size() / N;
            if (!m_valid) begin
                if (m_occ >= 1) begin
                    m_valid = 1'b1;
                    m_idx   = 0;
                end
            end else if (out_ready) begin
                if (m_idx == N - 1) begin
                    repeat (N) void'(fq.pop_front());
                    m_idx   = 0;
                    m_valid = (m_occ >= 2);
                end else begin
                    m_idx++;
                end
            end
            if (in_valid) begin
                if (m_occ < 2) begin
                    part[brev(m_wcnt)] = {di_re, di_im};
                    m_wcnt++;
                    if (m_wcnt == N) begin
                        for (int j = 0; j < N; j++) fq.push_back(part[j]);
                        m_wcnt = 0;
                    end
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Compare process: DUT against model on every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("m_out_valid", out_valid, m_valid);
            check("m_overflow", overflow, m_ovf);
            if (m_valid) begin
                cmp_e = fq[m_idx];
                check("m_out_idx", out_idx, m_idx);
                check("m_do_re", do_re, cmp_e[127:64]);
                check("m_do_im", do_im, cmp_e[63:0] ^ IMF);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int base, input logic [63:0] im, input logic rnd_im);
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            di_re = 64'(base + brev(k));
            di_im = rnd_im ? {$urandom, $urandom} : im;
            step();
        end
    endtask

    task automatic wait_valid(input string nm);
        for (int t = 0; t < 40 && !out_valid; t++) step();
        check(nm, out_valid, 1'b1);
    endtask

    task automatic expect_frame(input int base, input string nm);
        wait_valid(nm);
        for (int i = 0; i < N; i++) begin
            check({nm, "_idx"}, out_idx, i);
            check({nm, "_re"}, do_re, 64'(base + i));
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] h_re;
        logic [63:0] h_im;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_re", do_re, 64'h0);
        check("rst_im", do_im, 64'h0);
        check("rst_idx", out_idx, 0);
        check("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;
        step();

        // Single frame: re equals the natural index, latency of one edge after the last sample.
        out_ready = 1'b1;
        push_frame(0, 64'h0, 1'b1);
        in_valid = 1'b0;
        check("lat_edge_e", out_valid, 1'b0);
        step();
        check("lat_edge_e1_valid", out_valid, 1'b1);
        check("lat_edge_e1_idx", out_idx, 0);
        check("lat_edge_e1_re", do_re, 64'd0);
        expect_frame(0, "single");
        check("single_end", out_valid, 1'b0);

        // Backpressure at index 3 for five cycles.
        push_frame(100, 64'h0, 1'b1);
        in_valid = 1'b0;
        for (int t = 0; t < 40 && !(out_valid && out_idx == 3); t++) step();
        check("bp_reach3", out_idx, 3);
        out_ready = 1'b0;
        h_re = do_re;
        h_im = do_im;
        check("bp_re3", h_re, 64'd103);
        for (int t = 0; t < 5; t++) begin
            step();
            check("bp_hold_idx", out_idx, 3);
            check("bp_hold_re", do_re, h_re);
            check("bp_hold_im", do_im, h_im);
            check("bp_hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        step();
        check("bp_resume_idx", out_idx, 4);
        check("bp_resume_re", do_re, 64'd104);
        repeat (6) step();
        check("bp_end", out_valid, 1'b0);

        // Back-to-back frames with no bubble.
        fork
            begin
                push_frame(700, 64'h0, 1'b1);
                push_frame(800, 64'h0, 1'b1);
                in_valid = 1'b0;
            end
            begin
                wait_valid("b2b_start");
                for (int i = 0; i < 2 * N; i++) begin
                    check("b2b_valid", out_valid, 1'b1);
                    check("b2b_re", do_re, (i < N) ? 64'(700 + i) : 64'(800 + i - N));
                    step();
                end
            end
        join
        check("b2b_ovf", overflow, 1'b0);
        check("b2b_end", out_valid, 1'b0);

        // Overflow: three frames pushed with the reader stalled.
        out_ready = 1'b0;
        push_frame(200, 64'h0, 1'b1);
        push_frame(300, 64'h0, 1'b1);
        check("ovf_before", overflow, 1'b0);
        push_frame(400, 64'h0, 1'b1);
        in_valid = 1'b0;
        check("ovf_set", overflow, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            check("ovf_rd_valid", out_valid, 1'b1);
            check("ovf_rd_re", do_re, (i < N) ? 64'(200 + i) : 64'(300 + i - N));
            step();
        end
        check("ovf_drained", out_valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        // Reset mid-frame while a frame is being presented.
        out_ready = 1'b0;
        push_frame(500, 64'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            di_re = 64'(550 + k);
            step();
        end
        in_valid = 1'b0;
        check("mid_pre_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_re", do_re, 64'h0);
        check("mid_rst_im", do_im, 64'h0);
        check("mid_rst_ovf", overflow, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push_frame(600, 64'h0, 1'b1);
        in_valid = 1'b0;
        expect_frame(600, "post_rst");

        // Imaginary part pass-through (sign inverted when conjugation is built in).
        push_frame(900, 64'h3FF0000000000000, 1'b0);
        in_valid = 1'b0;
        wait_valid("conj_start");
`ifdef FFT_OUT_CONJ_EN
        check("conj_im", do_im, 64'hBFF0000000000000);
`else
        check("conj_im", do_im, 64'h3FF0000000000000);
`endif
        check("conj_re", do_re, 64'd900);
        repeat (N + 2) step();

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 55);
            di_re = {$urandom, $urandom};
            di_im = {$urandom, $urandom};
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();
        check("final_idle", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
